bitbakery_serial_frame_tx: RTL and testbench

Parametrised UART-style frame transmitter for BitBakery game state. It replaces the fixed 8E1, always-running transmitter. It serialises a sync header byte followed by NBYTES payload bytes, with configurable bit period, parity mode, stop-bit count and inter-frame gap. It supports one-shot or continuous operation and a start/busy/frame_done handshake, and sits between the game datapath (score, state, obstacle map) and the serial pin.

---
 rtl/bitbakery_serial_frame_tx.sv | 160 ++++++++++++++++
 tb/tb_bitbakery_serial_frame_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitbakery_serial_frame_tx.sv
// UART-style frame transmitter: a sync header byte then NBYTES payload bytes.
// Bit period, parity, stop bits and the inter-frame gap are set by parameters.
module bitbakery_serial_frame_tx #(
  parameter int unsigned CLK_DIV   = 434,
  parameter int unsigned NBYTES    = 67,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 1,
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter int unsigned GAP_BITS  = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [8*NBYTES-1:0] payload,
  input  logic                start,
  input  logic                continuous,
  output logic                busy,
  output logic                frame_done,
  output logic                saida_serial
);

  localparam int unsigned TW     = $clog2(CLK_DIV);
  localparam int unsigned BIW    = $clog2(NBYTES + 1);
  localparam int unsigned BC_MAX = (GAP_BITS > 8) ? GAP_BITS : 8;
  localparam int unsigned BCW    = $clog2(BC_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [BIW-1:0]      byte_idx_q, byte_idx_d;
  logic [8*NBYTES-1:0] shadow_q, shadow_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                saida_serial_q, saida_serial_d;

  logic                bit_end;
  logic                gap_end;
  logic [7:0]          cur_byte;

  // Next-state: bit timer, bit/byte counters and payload shadow
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    gap_end    = 1'b0;
    bit_end    = (timer_q == TW'(CLK_DIV - 1));

    if (state_q != S_IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      S_IDLE: ;
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BCW'(7)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            if (byte_idx_q == BIW'(NBYTES)) begin
              if (GAP_BITS == 0) gap_end = 1'b1;
              else               state_d = S_GAP;
            end else begin
              byte_idx_d = byte_idx_q + BIW'(1);
              // header slot does not consume shadow; payload slots shift it down
              if (byte_idx_q != '0) shadow_d = shadow_q >> 8;
              state_d = S_START;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (bit_cnt_q == BCW'(GAP_BITS - 1)) gap_end = 1'b1;
          else                                 bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (gap_end) state_d = S_IDLE;

    if ((state_q == S_IDLE && (start || continuous)) || (gap_end && continuous)) begin
      state_d    = S_START;
      timer_d    = '0;
      bit_cnt_d  = '0;
      byte_idx_d = '0;
      shadow_d   = payload;
    end
  end

  // Outputs are derived from next-state values so they register in step with the state
  always_comb begin
    cur_byte       = (byte_idx_d == '0) ? HEADER : shadow_d[7:0];
    busy_d         = (state_d != S_IDLE);
    frame_done_d   = (state_d == S_STOP) && (timer_d == TW'(CLK_DIV - 1)) &&
                     (bit_cnt_d == BCW'(STOP_BITS - 1)) && (byte_idx_d == BIW'(NBYTES));
    saida_serial_d = 1'b1;
    case (state_d)
      S_START: saida_serial_d = 1'b0;
      S_DATA:  saida_serial_d = cur_byte[bit_cnt_d[2:0]];
      S_PAR:   saida_serial_d = (^cur_byte) ^ (PARITY == 2);
      default: saida_serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      bit_cnt_q      <= '0;
      byte_idx_q     <= '0;
      shadow_q       <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      saida_serial_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_idx_q     <= byte_idx_d;
      shadow_q       <= shadow_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      saida_serial_q <= saida_serial_d;
    end
  end

  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign saida_serial = saida_serial_q;

endmodule

// File: tb/tb_bitbakery_serial_frame_tx.sv
// Bench for bitbakery_serial_frame_tx: even-parity, odd-parity and gap instances
// share stimulus; expected characters are queued and compared as the line is captured.
module tb_bitbakery_serial_frame_tx;

  localparam int CLK_DIV = 4;
  localparam int NB      = 2;
  localparam int CB      = 11;
  localparam int FRAME   = (NB + 1) * CB * CLK_DIV;
  localparam int GAPC    = 2 * CLK_DIV;

  logic        clock;
  logic        reset;
  logic [15:0] payload;
  logic        start;
  logic        continuous;
  logic [2:0]  ser, bsy, dn;
  logic [1:0]  sel;
  logic        mon_line, mon_busy, mon_done;

  int errors;
  int checks;
  logic [10:0] exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mon_line = ser[sel];
  assign mon_busy = bsy[sel];
  assign mon_done = dn[sel];

  bitbakery_serial_frame_tx #(.CLK_DIV(4), .NBYTES(2), .PARITY(1), .STOP_BITS(1),
                              .HEADER(8'hA5), .GAP_BITS(0)) u_even (
    .clock(clock), .reset(reset), .payload(payload), .start(start), .continuous(continuous),
    .busy(bsy[0]), .frame_done(dn[0]), .saida_serial(ser[0]));

  bitbakery_serial_frame_tx #(.CLK_DIV(4), .NBYTES(2), .PARITY(2), .STOP_BITS(1),
                              .HEADER(8'hA5), .GAP_BITS(0)) u_odd (
    .clock(clock), .reset(reset), .payload(payload), .start(start), .continuous(continuous),
    .busy(bsy[1]), .frame_done(dn[1]), .saida_serial(ser[1]));

  bitbakery_serial_frame_tx #(.CLK_DIV(4), .NBYTES(2), .PARITY(1), .STOP_BITS(1),
                              .HEADER(8'hA5), .GAP_BITS(2)) u_gap (
    .clock(clock), .reset(reset), .payload(payload), .start(start), .continuous(continuous),
    .busy(bsy[2]), .frame_done(dn[2]), .saida_serial(ser[2]));

  // Time-ordered character: start, 8 data LSB first, parity, stop
  function automatic logic [10:0] char_vec(input logic [7:0] b, input logic odd);
    return {1'b1, (^b) ^ odd, b, 1'b0};
  endfunction

  task automatic push_frame(input logic [15:0] pl, input logic odd);
    exp_q.push_back(char_vec(8'hA5, odd));
    exp_q.push_back(char_vec(pl[7:0], odd));
    exp_q.push_back(char_vec(pl[15:8], odd));
  endtask

  // Entered at the negedge of frame cycle 1; leaves at the negedge of cycle FRAME+1
  task automatic check_frame(input string tag, input int pl_cyc, input logic [15:0] pl_new,
                             input int st_cyc, input int cd_cyc);
    logic [10:0] cap [NB+1];
    logic [10:0] exp;
    int cyc, done_first, done_cnt, busy_low, width_err;
    done_first = 0; done_cnt = 0; busy_low = 0; width_err = 0;
    for (int c = 0; c < NB + 1; c++)
      for (int b = 0; b < CB; b++)
        for (int k = 0; k < CLK_DIV; k++) begin
          cyc = (c * CB + b) * CLK_DIV + k + 1;
          if (k == 0) cap[c][b] = mon_line;
          else if (mon_line !== cap[c][b]) width_err++;
          if (mon_done === 1'b1) begin
            done_cnt++;
            if (done_first == 0) done_first = cyc;
          end
          if (mon_busy !== 1'b1) busy_low++;
          if (cyc == pl_cyc) payload = pl_new;
          start = (cyc == st_cyc);
          if (cyc == cd_cyc) continuous = 1'b0;
          @(negedge clock);
        end
    for (int c = 0; c < NB + 1; c++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s char%0d: got %b, no expected character queued", tag, c, cap[c]);
      end else begin
        exp = exp_q.pop_front();
        if (cap[c] !== exp) begin
          errors++;
          $display("FAIL %s char%0d: got %b expected %b", tag, c, cap[c], exp);
        end
      end
    end
    checks++;
    if (width_err !== 0) begin
      errors++; $display("FAIL %s bit_width: %0d unstable cycles, expected 0", tag, width_err);
    end
    checks++;
    if (done_first !== FRAME) begin
      errors++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_first, FRAME);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++; $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt);
    end
    checks++;
    if (busy_low !== 0) begin
      errors++; $display("FAIL %s busy_in_frame: low for %0d cycles, expected 0", tag, busy_low);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({mon_line, mon_busy, mon_done} !== 3'b100) begin
      errors++;
      $display("FAIL %s idle: got line/busy/done=%b expected 100", tag, {mon_line, mon_busy, mon_done});
    end
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (5) begin
      @(negedge clock);
      checks++;
      if ({ser, bsy, dn} !== 9'b111_000_000) begin
        errors++;
        $display("FAIL reset: got ser/busy/done=%b expected 111000000", {ser, bsy, dn});
      end
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_one_shot();
    sel = 2'd0;
    payload = 16'h0781;
    push_frame(16'h0781, 1'b0);
    pulse_start();
    check_frame("one_shot", 0, 16'h0000, 0, 0);
    check_idle("one_shot_end");
    repeat (20) @(negedge clock);
  endtask

  task automatic test_odd_parity();
    sel = 2'd1;
    payload = 16'h0000;
    push_frame(16'h0000, 1'b1);
    pulse_start();
    check_frame("odd_parity", 0, 16'h0000, 0, 0);
    check_idle("odd_parity_end");
    repeat (20) @(negedge clock);
  endtask

  task automatic test_snapshot();
    sel = 2'd0;
    payload = 16'h0781;
    push_frame(16'h0781, 1'b0);
    pulse_start();
    check_frame("snapshot", 50, 16'hFFFF, 60, 0);
    check_idle("snapshot_end");
    repeat (7) @(negedge clock);
    check_idle("snapshot_no_queue");
    repeat (20) @(negedge clock);
  endtask

  task automatic test_continuous();
    int gap_hi, gap_bad, bad;
    sel = 2'd2;
    payload = 16'h0781;
    push_frame(16'h0781, 1'b0);
    @(negedge clock) continuous = 1'b1;
    @(negedge clock);
    check_frame("cont_frame1", 50, 16'h3C5A, 0, 0);
    gap_hi = 0; gap_bad = 0;
    while (mon_line === 1'b1 && gap_hi < 20) begin
      if (mon_busy !== 1'b1 || mon_done !== 1'b0) gap_bad++;
      gap_hi++;
      @(negedge clock);
    end
    checks++;
    if (gap_hi !== GAPC) begin
      errors++; $display("FAIL cont_gap_len: got %0d high cycles expected %0d", gap_hi, GAPC);
    end
    checks++;
    if (gap_bad !== 0) begin
      errors++; $display("FAIL cont_gap_flags: %0d bad busy/done cycles, expected 0", gap_bad);
    end
    push_frame(16'h3C5A, 1'b0);
    check_frame("cont_frame2", 0, 16'h0000, 0, 30);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (mon_line !== 1'b1 || mon_busy !== (k < GAPC) || mon_done !== 1'b0) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL cont_stop: %0d bad cycles after final frame, expected 0", bad);
    end
    repeat (20) @(negedge clock);
  endtask

  task automatic test_reset_mid_frame();
    sel = 2'd0;
    payload = 16'h0781;
    pulse_start();
    repeat (59) @(negedge clock);
    checks++;
    if (mon_line !== 1'b0) begin
      errors++; $display("FAIL mid_reset_pre: got line %b expected 0", mon_line);
    end
    reset = 1'b1;
    @(negedge clock);
    check_idle("mid_reset_after");
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check_idle("mid_reset_quiet");
    push_frame(16'h0781, 1'b0);
    pulse_start();
    check_frame("fresh_frame", 0, 16'h0000, 0, 0);
    check_idle("fresh_frame_end");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    payload = '0;
    sel = 2'd0;
    test_reset();
    test_one_shot();
    test_odd_parity();
    test_snapshot();
    test_continuous();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
